dmem_sramlike_responder: RTL and testbench
==========================================

Name: dmem_sramlike_responder

Overview:
- Responder for the datapath's data-memory request port (en/we/sel/size/addr/wdata in MEM, rdata back, stallreq_from_mem out).
- Converts each single-instruction MEM-stage request into one sram-like bus transaction (req/addr_ok/data_ok).
- Stalls the pipeline until the transaction completes, then returns load data exactly once.
- Sits between the CPU core and the data cache / AXI bridge.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte strobe width is DATA_W/8)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cpu_en  in  1  MEM-stage access valid (already gated by mem_flush)
- cpu_we  in  1  store when 1, load when 0
- cpu_sel  in  DATA_W/8  byte enables, forwarded unchanged
- cpu_size  in  2  0=byte, 1=half, 2=word
- cpu_addr  in  ADDR_W  physical address
- cpu_wdata  in  DATA_W  store data, already lane-aligned
- cpu_flush  in  1  MEM flush (exception/eret)
- pipe_stall  in  1  global pipeline stall from other sources
- cpu_rdata  out  DATA_W  load data to MEM stage
- stallreq  out  1  stall request (stallreq_from_mem)
- data_req  out  1  bus request
- data_wr  out  1  bus write
- data_size  out  2  bus size
- data_wstrb  out  DATA_W/8  bus byte strobes
- data_addr  out  ADDR_W  bus address
- data_wdata  out  DATA_W  bus write data
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  data phase done (read data valid / write acknowledged)
- data_rdata  in  DATA_W  bus read data

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, data_req=0, stallreq=0, cpu_rdata=0, kill=0, captured request fields=0.
- States:
  - IDLE: data_req=cpu_en; bus fields driven combinationally from cpu_*; stallreq=cpu_en.
    - cpu_en & addr_ok: latch fields, go WAIT.
    - cpu_en & !addr_ok: latch fields, go REQ.
  - REQ: data_req=1 from latched fields; stallreq=1. addr_ok: go WAIT.
  - WAIT: data_req=0; stallreq=1. data_ok: go DONE, or go IDLE if kill. A load captures data_rdata into cpu_rdata; a store leaves cpu_rdata unchanged.
  - DONE: stallreq=0, cpu_rdata held. Stays in DONE while pipe_stall=1, else goes IDLE. cpu_en seen in DONE belongs to the completed instruction and is never reissued.
- Minimum latency: addr_ok in the IDLE cycle plus data_ok on the next cycle gives 2 stall cycles; the instruction advances on the DONE cycle.
- data_req, once raised, is held with stable fields until addr_ok. It is never withdrawn.
- cpu_flush in REQ or WAIT: set kill. The transaction still completes and its data is discarded. stallreq stays 1 until data_ok, then state goes IDLE (not DONE) and kill clears.
- cpu_flush in IDLE: no request issued, because cpu_en is already low.
- cpu_flush in DONE: go IDLE.
- addr_ok and data_ok in the same cycle as the request (REQ/IDLE): data_ok is accepted only in WAIT, so the bus side never returns data_ok in the addr_ok cycle.
- data_ok with no outstanding request: ignored.
- Only one outstanding transaction at a time; there is no pipelining of requests.
- data_wstrb=cpu_sel when data_wr=1, otherwise all ones.

Decomposition:
- Shared package/header (defines.vh): state encodings DMR_IDLE/REQ/WAIT/DONE, size codes SIZE_B/H/W.
- Single module. No sub-module is required; the FSM and the capture registers fit in one file.

Test Plan:
1. Load, cpu_addr=0x8000_0010, addr_ok in the IDLE cycle, data_ok one cycle later with rdata=0xDEADBEEF -> stallreq high for 2 cycles, DONE cycle cpu_rdata=0xDEADBEEF, exactly one data_req beat.
2. Store, sel=4'b0011, size=1, addr_ok delayed 3 cycles -> data_req held 4 cycles with constant addr/wdata/wstrb=0011, stallreq deasserts only in DONE.
3. Load completes while pipe_stall=1 for 3 cycles, cpu_en held -> remains DONE, no second data_req, cpu_rdata stable; returns to IDLE when pipe_stall drops.
4. cpu_flush pulses in WAIT, then data_ok with rdata=0x12345678 -> state goes IDLE directly, cpu_rdata keeps its old value, stallreq drops after data_ok.
5. Back-to-back loads to 0x0 then 0x4 -> two distinct transactions; second data_req appears in the cycle after DONE.
6. rst driven low mid-WAIT -> outputs immediately at reset values; after release an immediate cpu_en issues a fresh data_req.

Source files
------------

// File: rtl/dmem_sramlike_responder_pkg.sv
// Shared types for the data-memory sram-like responder: FSM states and bus size codes.
package dmem_sramlike_responder_pkg;

  typedef enum logic [1:0] {
    DmrIdle,
    DmrReq,
    DmrWait,
    DmrDone
  } dmr_state_e;

  localparam logic [1:0] SizeB = 2'd0;
  localparam logic [1:0] SizeH = 2'd1;
  localparam logic [1:0] SizeW = 2'd2;

endpackage

// File: rtl/dmem_sramlike_responder.sv
// Turns one MEM-stage data access into a single sram-like bus transaction, stalling the
// pipeline until it completes and handing load data back exactly once.
module dmem_sramlike_responder
  import dmem_sramlike_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic                cpu_we,
  input  logic [DATA_W/8-1:0] cpu_sel,
  input  logic [1:0]          cpu_size,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_flush,
  input  logic                pipe_stall,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                stallreq,
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [DATA_W/8-1:0] data_wstrb,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  localparam int unsigned StrbW = DATA_W / 8;

  dmr_state_e          state_q, state_d;
  logic                kill_q, kill_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                we_q;
  logic [StrbW-1:0]    sel_q;
  logic [1:0]          size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                capture;
  logic [StrbW-1:0]    bus_sel;

  // Fields are taken straight from the core in IDLE so a request can issue with zero delay.
  assign capture    = (state_q == DmrIdle) && cpu_en;
  assign data_wr    = (state_q == DmrIdle) ? cpu_we    : we_q;
  assign bus_sel    = (state_q == DmrIdle) ? cpu_sel   : sel_q;
  assign data_size  = (state_q == DmrIdle) ? cpu_size  : size_q;
  assign data_addr  = (state_q == DmrIdle) ? cpu_addr  : addr_q;
  assign data_wdata = (state_q == DmrIdle) ? cpu_wdata : wdata_q;
  assign data_wstrb = data_wr ? bus_sel : {StrbW{1'b1}};
  assign cpu_rdata  = rdata_q;

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    rdata_d  = rdata_q;
    data_req = 1'b0;
    stallreq = 1'b0;
    unique case (state_q)
      DmrIdle: begin
        data_req = cpu_en;
        stallreq = cpu_en;
        if (cpu_en) begin
          state_d = data_addr_ok ? DmrWait : DmrReq;
        end
      end
      DmrReq: begin
        data_req = 1'b1;
        stallreq = 1'b1;
        if (cpu_flush) begin
          kill_d = 1'b1;
        end
        if (data_addr_ok) begin
          state_d = DmrWait;
        end
      end
      DmrWait: begin
        stallreq = 1'b1;
        if (cpu_flush) begin
          kill_d = 1'b1;
        end
        if (data_data_ok) begin
          kill_d = 1'b0;
          // A flush landing together with data_ok still discards the data.
          if (kill_q || cpu_flush) begin
            state_d = DmrIdle;
          end else begin
            state_d = DmrDone;
            if (!we_q) begin
              rdata_d = data_rdata;
            end
          end
        end
      end
      DmrDone: begin
        if (cpu_flush || !pipe_stall) begin
          state_d = DmrIdle;
        end
      end
      default: state_d = DmrIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DmrIdle;
      kill_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      sel_q   <= '0;
      size_q  <= SizeB;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= cpu_we;
      sel_q   <= cpu_sel;
      size_q  <= cpu_size;
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_sramlike_responder.sv
// Directed, table-driven bench for dmem_sramlike_responder plus a hand-written reset sequence.
module tb_dmem_sramlike_responder;

  logic        clk;
  logic        rst;
  logic        cpu_en, cpu_we, cpu_flush, pipe_stall;
  logic [3:0]  cpu_sel;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stallreq, data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int errors = 0;
  int checks = 0;

  dmem_sramlike_responder #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_en       (cpu_en),
    .cpu_we       (cpu_we),
    .cpu_sel      (cpu_sel),
    .cpu_size     (cpu_size),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_flush    (cpu_flush),
    .pipe_stall   (pipe_stall),
    .cpu_rdata    (cpu_rdata),
    .stallreq     (stallreq),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en, we;
    logic [3:0]  sel;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    logic        fl, ps, aok, dok;
    logic [31:0] rd;
    logic        e_st, e_rq, e_wr;
    logic [3:0]  e_sb;
    logic [1:0]  e_sz;
    logic [31:0] e_a, e_wd, e_rdat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, we, input logic [3:0] sel, input logic [1:0] sz,
                     input logic [31:0] a, wd, input logic fl, ps, aok, dok,
                     input logic [31:0] rd, input logic e_st, e_rq, e_wr,
                     input logic [3:0] e_sb, input logic [1:0] e_sz,
                     input logic [31:0] e_a, e_wd, e_rdat);
    vec_t v;
    v.en = en; v.we = we; v.sel = sel; v.sz = sz; v.a = a; v.wd = wd;
    v.fl = fl; v.ps = ps; v.aok = aok; v.dok = dok; v.rd = rd;
    v.e_st = e_st; v.e_rq = e_rq; v.e_wr = e_wr; v.e_sb = e_sb; v.e_sz = e_sz;
    v.e_a = e_a; v.e_wd = e_wd; v.e_rdat = e_rdat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    cpu_en = 0; cpu_we = 0; cpu_sel = 4'hf; cpu_size = 2'd2; cpu_addr = '0; cpu_wdata = '0;
    cpu_flush = 0; pipe_stall = 0; data_addr_ok = 0; data_data_ok = 0; data_rdata = '0;
  endtask

  initial begin
    // 1: load with minimum latency
    add(1,0,'hf,2,'h80000010,0, 0,0,1,0,0,          1,1,0,'hf,2,'h80000010,0,0);
    add(1,0,'hf,2,'h80000010,0, 0,0,0,1,'hdeadbeef, 1,0,0,0,0,0,0,0);
    add(1,0,'hf,2,'h80000010,0, 0,0,0,0,0,          0,0,0,0,0,0,0,'hdeadbeef);
    add(0,0,'hf,2,0,0,          0,0,0,0,0,          0,0,0,0,0,0,0,'hdeadbeef);
    // 2: halfword store, addr_ok after 3 cycles; core inputs wander but bus fields must not
    add(1,1,'h3,1,'h100,'habcd,     0,0,0,0,0, 1,1,1,'h3,1,'h100,'habcd,'hdeadbeef);
    add(1,1,'hc,2,'h200,'hffff0000, 0,0,0,0,0, 1,1,1,'h3,1,'h100,'habcd,'hdeadbeef);
    add(1,1,'hc,2,'h200,'hffff0000, 0,0,0,0,0, 1,1,1,'h3,1,'h100,'habcd,'hdeadbeef);
    add(1,1,'hc,2,'h200,'hffff0000, 0,0,1,0,0, 1,1,1,'h3,1,'h100,'habcd,'hdeadbeef);
    add(1,1,'h3,1,'h100,'habcd, 0,0,0,1,'h55555555, 1,0,0,0,0,0,0,'hdeadbeef);
    add(1,1,'h3,1,'h100,'habcd, 0,0,0,0,0,          0,0,0,0,0,0,0,'hdeadbeef);
    add(0,0,'hf,2,0,0,          0,0,0,0,0,          0,0,0,0,0,0,0,'hdeadbeef);
    // 3: byte load finishing under pipe_stall; stray addr_ok/data_ok in DONE ignored
    add(1,0,'h2,0,'h41,0, 0,0,1,0,0,          1,1,0,'hf,0,'h41,0,'hdeadbeef);
    add(1,0,'h2,0,'h41,0, 0,1,0,1,'hcafef00d, 1,0,0,0,0,0,0,'hdeadbeef);
    for (int i = 0; i < 3; i++) begin
      add(1,0,'h2,0,'h41,0, 0,1,1,1,'hbad,    0,0,0,0,0,0,0,'hcafef00d);
    end
    add(1,0,'h2,0,'h41,0, 0,0,0,0,0,          0,0,0,0,0,0,0,'hcafef00d);
    add(0,0,'hf,2,0,0,    0,0,0,0,0,          0,0,0,0,0,0,0,'hcafef00d);
    // 4: flush in WAIT discards the data and returns straight to IDLE
    add(1,0,'hf,2,'h80,0, 0,0,1,0,0,          1,1,0,'hf,2,'h80,0,'hcafef00d);
    add(0,0,'hf,2,'h80,0, 1,0,0,0,0,          1,0,0,0,0,0,0,'hcafef00d);
    add(0,0,'hf,2,'h80,0, 0,0,0,1,'h12345678, 1,0,0,0,0,0,0,'hcafef00d);
    // 5: back-to-back loads; the next request must issue in the cycle right after DONE
    add(1,0,'hf,2,'h0,0, 0,0,1,0,0,          1,1,0,'hf,2,'h0,0,'hcafef00d);
    add(1,0,'hf,2,'h0,0, 0,0,0,1,'h11111111, 1,0,0,0,0,0,0,'hcafef00d);
    add(1,0,'hf,2,'h0,0, 0,0,0,0,0,          0,0,0,0,0,0,0,'h11111111);
    add(1,0,'hf,2,'h4,0, 0,0,1,0,0,          1,1,0,'hf,2,'h4,0,'h11111111);
    add(1,0,'hf,2,'h4,0, 0,0,0,1,'h22222222, 1,0,0,0,0,0,0,'h11111111);
    // flush in DONE overrides pipe_stall
    add(1,0,'hf,2,'h4,0, 1,1,0,0,0,          0,0,0,0,0,0,0,'h22222222);
    // flush in REQ: request still held until addr_ok, data discarded
    add(1,0,'hf,2,'h8,0, 0,0,0,0,0,          1,1,0,'hf,2,'h8,0,'h22222222);
    add(0,0,'hf,2,'h8,0, 1,0,1,0,0,          1,1,0,'hf,2,'h8,0,'h22222222);
    add(0,0,'hf,2,'h8,0, 0,0,0,1,'h33333333, 1,0,0,0,0,0,0,'h22222222);
    // data_ok with nothing outstanding, then data_ok in the addr_ok cycle: both ignored
    add(0,0,'hf,2,'h0,0, 0,0,0,1,'h44444444, 0,0,0,0,0,0,0,'h22222222);
    add(1,0,'hf,2,'hc,0, 0,0,1,1,'h55555555, 1,1,0,'hf,2,'hc,0,'h22222222);
    add(1,0,'hf,2,'hc,0, 0,0,0,0,0,          1,0,0,0,0,0,0,'h22222222);
    add(1,0,'hf,2,'hc,0, 0,0,0,1,'h66666666, 1,0,0,0,0,0,0,'h22222222);
    add(1,0,'hf,2,'hc,0, 0,0,0,0,0,          0,0,0,0,0,0,0,'h66666666);
    add(0,0,'hf,2,0,0,   0,0,0,0,0,          0,0,0,0,0,0,0,'h66666666);

    rst = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    #1;
    chk("reset stallreq", {31'b0, stallreq}, 32'd0);
    chk("reset data_req", {31'b0, data_req}, 32'd0);
    chk("reset cpu_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      cpu_en = vecs[i].en; cpu_we = vecs[i].we; cpu_sel = vecs[i].sel;
      cpu_size = vecs[i].sz; cpu_addr = vecs[i].a; cpu_wdata = vecs[i].wd;
      cpu_flush = vecs[i].fl; pipe_stall = vecs[i].ps; data_addr_ok = vecs[i].aok;
      data_data_ok = vecs[i].dok; data_rdata = vecs[i].rd;
      #1;
      chk($sformatf("v%0d stallreq", i), {31'b0, stallreq}, {31'b0, vecs[i].e_st});
      chk($sformatf("v%0d data_req", i), {31'b0, data_req}, {31'b0, vecs[i].e_rq});
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, vecs[i].e_rdat);
      if (vecs[i].e_rq) begin
        chk($sformatf("v%0d data_wr", i), {31'b0, data_wr}, {31'b0, vecs[i].e_wr});
        chk($sformatf("v%0d data_wstrb", i), {28'b0, data_wstrb}, {28'b0, vecs[i].e_sb});
        chk($sformatf("v%0d data_size", i), {30'b0, data_size}, {30'b0, vecs[i].e_sz});
        chk($sformatf("v%0d data_addr", i), data_addr, vecs[i].e_a);
        chk($sformatf("v%0d data_wdata", i), data_wdata, vecs[i].e_wd);
      end
    end

    // 6: asynchronous reset in the middle of WAIT, then a fresh request right after release
    @(negedge clk);
    drive_idle();
    cpu_en = 1; cpu_addr = 32'h90; data_addr_ok = 1;
    #1;
    chk("r6 issue data_req", {31'b0, data_req}, 32'd1);
    @(negedge clk);
    data_addr_ok = 0;
    #1;
    chk("r6 wait stallreq", {31'b0, stallreq}, 32'd1);
    #2;
    rst = 1'b0;
    cpu_en = 0;
    #1;
    chk("r6 async stallreq", {31'b0, stallreq}, 32'd0);
    chk("r6 async data_req", {31'b0, data_req}, 32'd0);
    chk("r6 async cpu_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cpu_en = 1; cpu_addr = 32'h94;
    #1;
    chk("r6 fresh data_req", {31'b0, data_req}, 32'd1);
    chk("r6 fresh stallreq", {31'b0, stallreq}, 32'd1);
    chk("r6 fresh data_addr", data_addr, 32'h94);
    @(negedge clk);
    cpu_addr = 32'h98;
    data_addr_ok = 1;
    #1;
    chk("r6 held data_req", {31'b0, data_req}, 32'd1);
    chk("r6 held data_addr", data_addr, 32'h94);
    @(negedge clk);
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h77777777;
    #1;
    chk("r6 wait data_req", {31'b0, data_req}, 32'd0);
    @(negedge clk);
    data_data_ok = 0;
    #1;
    chk("r6 done stallreq", {31'b0, stallreq}, 32'd0);
    chk("r6 done cpu_rdata", cpu_rdata, 32'h77777777);
    @(negedge clk);
    cpu_en = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
